calc_port_responder: RTL and testbench
======================================

Name: calc_port_responder

Overview:
- Responder end of the calc1 request interface: the device that receives cmd/operand sequences on NUM_PORTS request ports and returns a response code plus data per port.
- Serves as the behavioural/synthesizable DUT-side model that the calc1 stimulus driver targets.
- Per-port capture FSMs feed one shared ALU pipeline through a round-robin arbiter.
- Responses return on the originating port.

Parameters:
- NUM_PORTS, 4, number of request/response ports; ports are indexed 1..NUM_PORTS.
- LATENCY, 1, ALU pipeline stages between grant and response; must be >= 1.

Ports:
- c_clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_cmd_in[1:NUM_PORTS]  input  [0:3] each  command per port: 0 NOP, 1 ADD, 2 SUB, 5 LSH, 6 RSH; all other codes are invalid.
- req_data_in[1:NUM_PORTS]  input  [0:31] each  operand 1 in the cmd cycle, operand 2 in the following cycle.
- out_resp[1:NUM_PORTS]  output  [0:1] each  response code: 0 none, 1 success, 2 overflow/underflow/invalid, 3 reserved (never driven).
- out_data[1:NUM_PORTS]  output  [0:31] each  result; valid only while out_resp is nonzero, 0 otherwise.
- port_busy[1:NUM_PORTS]  output  1 each  port holds an unanswered request.
- drop_err[1:NUM_PORTS]  output  1 each  sticky flag: a command arrived while the port was busy.

Behaviour:
- Reset (async assert, sync deassert): all outputs 0, all port FSMs IDLE, ALU pipeline emptied, round-robin pointer set to port 1. In-flight requests are discarded and no response is issued for them.
- Per-port FSM:
  - IDLE -> WAIT_OP2 when cmd != 0 at an edge; latch cmd and op1.
  - WAIT_OP2 -> PENDING at the next edge unconditionally; latch op2 from data. The cmd value in this cycle is ignored and is not a new command.
  - PENDING -> INFLIGHT on the edge where this port is granted.
  - INFLIGHT -> IDLE on the edge the response register for this port is loaded.
- Busy ports: port_busy = 1 in WAIT_OP2, PENDING and INFLIGHT.
  - A nonzero cmd seen in PENDING or INFLIGHT is dropped and sets drop_err. drop_err clears only on reset.
  - A new cmd may be presented in the cycle the response is visible; it is accepted.
- Arbiter: one grant per cycle among PENDING ports. Search starts at the port after the last granted port and wraps from NUM_PORTS to 1. The pointer advances only on a grant.
- Timing, uncontended (cmd in cycle N): op2 sampled at the end of N+1, grant in N+2, response visible in cycle N+2+LATENCY for exactly one cycle, then out_resp and out_data return to 0.
- Pipeline: fully pipelined; a new grant is accepted every cycle.
- Arithmetic (unsigned 32-bit; bit 0 is MSB):
  - ADD: sum = op1 + op2. Carry out of bit 0 gives resp 2, data 0; otherwise resp 1, data = sum.
  - SUB: op2 > op1 gives resp 2, data 0; otherwise resp 1, data = op1 - op2. Equal operands give resp 1, data 0.
  - LSH/RSH: shift amount = op2[27:31] (5 bits), upper op2 bits ignored, zero fill. Result is always resp 1.
  - Invalid cmd (3, 4, 7-15): not sent to ALU arithmetic; passes through the pipeline and answers resp 2, data 0 with the same latency.
- Simultaneous events:
  - Two ports reaching PENDING in the same cycle are granted on consecutive cycles in round-robin order.
  - Responses for different ports may be visible in the same cycle. A port never has more than one outstanding request.

Decomposition:
- Shared package calc_pkg: command codes (CMD_NOP/ADD/SUB/LSH/RSH), response codes (RESP_NONE/OK/ERR), the port FSM state enum, and the 32-bit data typedef. The stimulus driver reuses the same constants.
- One sub-module: calc_alu_pipe. Inputs are cmd, op1, op2 and port tag. Outputs are resp, data and tag after LATENCY stages.
- The top module holds the port FSMs, the arbiter, and the response demux.

Test Plan:
- Port 1: ADD 0xFFFF0000 + 0x0000FFFF -> out_resp[1] = 1, out_data[1] = 0xFFFFFFFF in cycle N+3 (LATENCY=1); other ports stay 0.
- Port 2: ADD 0x80000000 + 0x80000000 -> resp 2, data 0. Port 3: SUB 0x00000001 - 0x00000002 -> resp 2, data 0.
- Port 4: LSH 0x00000001 by 0x00000024 (amount 4) -> resp 1, data 0x00000010. RSH 0x80000000 by 31 -> data 0x00000001. Cmd 3 -> resp 2, data 0.
- All 4 ports issue ADD 1+1 in the same cycle -> responses of 2 in cycles N+3, N+4, N+5, N+6 in order 1,2,3,4. A repeat burst follows the rotated pointer.
- Port 1 issues a second cmd while busy -> request dropped, drop_err[1] = 1, exactly one response. A cmd in the response cycle is accepted.
- Assert reset in cycle N+2 of a pending SUB -> all outputs 0 next cycle, no response ever issued for it. A new request after reset completes normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calc1 constants and types, reused by the responder and the stimulus driver.
// Data words are [0:31] with bit 0 as the MSB, matching the calc1 interface.
package calc_pkg;

  typedef logic [0:31] data_t;
  typedef logic [0:3]  cmd_t;
  typedef logic [0:1]  resp_t;

  localparam cmd_t CMD_NOP = 4'd0;
  localparam cmd_t CMD_ADD = 4'd1;
  localparam cmd_t CMD_SUB = 4'd2;
  localparam cmd_t CMD_LSH = 4'd5;
  localparam cmd_t CMD_RSH = 4'd6;

  localparam resp_t RESP_NONE = 2'd0;
  localparam resp_t RESP_OK   = 2'd1;
  localparam resp_t RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_OP2 = 2'd1,
    ST_PENDING  = 2'd2,
    ST_INFLIGHT = 2'd3
  } port_state_t;

  typedef struct packed {
    resp_t resp;
    data_t data;
  } result_t;

  function automatic logic cmd_known(cmd_t cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_LSH) || (cmd == CMD_RSH);
  endfunction

endpackage

// File: rtl/calc_alu_pipe.sv
// Shared ALU: evaluates one granted request per cycle and carries the result
// and originating port tag through LATENCY register stages.
module calc_alu_pipe #(
  parameter int LATENCY = 1,
  parameter int TAG_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [0:3]       in_cmd,
  input  logic [0:31]      in_op1,
  input  logic [0:31]      in_op2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             retire_vld,
  output logic [TAG_W-1:0] retire_tag,
  output logic             out_vld,
  output logic [0:1]       out_resp,
  output logic [0:31]      out_data,
  output logic [TAG_W-1:0] out_tag
);
  import calc_pkg::*;

  function automatic result_t alu_eval(cmd_t cmd, data_t a, data_t b);
    result_t     r;
    logic [32:0] sum;
    r.resp = RESP_OK;
    r.data = '0;
    sum    = {1'b0, a} + {1'b0, b};
    if (!cmd_known(cmd)) begin
      r.resp = RESP_ERR;
    end else begin
      case (cmd)
        CMD_ADD: if (sum[32]) r.resp = RESP_ERR; else r.data = sum[31:0];
        CMD_SUB: if (b > a)   r.resp = RESP_ERR; else r.data = a - b;
        CMD_LSH: r.data = a << b[27:31];
        default: r.data = a >> b[27:31];
      endcase
    end
    return r;
  endfunction

  logic             vld_p [1:LATENCY];
  logic [TAG_W-1:0] tag_p [1:LATENCY];
  result_t          res_p [1:LATENCY];

  // stage 1 evaluates; later stages only delay
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[1] <= in_vld;
      for (int i = 2; i <= LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    res_p[1] <= alu_eval(in_cmd, in_op1, in_op2);
    tag_p[1] <= in_tag;
    for (int i = 2; i <= LATENCY; i++) begin
      res_p[i] <= res_p[i-1];
      tag_p[i] <= tag_p[i-1];
    end
  end

  // retire marks the entry about to load the final (response) stage
  if (LATENCY == 1) begin : g_retire_grant
    assign retire_vld = in_vld;
    assign retire_tag = in_tag;
  end else begin : g_retire_stage
    assign retire_vld = vld_p[LATENCY-1];
    assign retire_tag = tag_p[LATENCY-1];
  end

  assign out_vld  = vld_p[LATENCY];
  assign out_resp = res_p[LATENCY].resp;
  assign out_data = res_p[LATENCY].data;
  assign out_tag  = tag_p[LATENCY];

endmodule

// File: rtl/calc_port_responder.sv
// calc1 responder: per-port capture FSMs, round-robin arbiter into the shared
// ALU pipeline, and response demux back to the originating port.
module calc_port_responder #(
  parameter int NUM_PORTS = 4,
  parameter int LATENCY   = 1
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req_cmd_in  [1:NUM_PORTS],
  input  logic [0:31] req_data_in [1:NUM_PORTS],
  output logic [0:1]  out_resp    [1:NUM_PORTS],
  output logic [0:31] out_data    [1:NUM_PORTS],
  output logic        port_busy   [1:NUM_PORTS],
  output logic        drop_err    [1:NUM_PORTS]
);
  import calc_pkg::*;

  localparam int TAG_W = $clog2(NUM_PORTS + 1);

  port_state_t      state     [1:NUM_PORTS];
  port_state_t      state_nxt [1:NUM_PORTS];
  logic             drop_q    [1:NUM_PORTS];
  logic             drop_set  [1:NUM_PORTS];
  cmd_t             cmd_q     [1:NUM_PORTS];
  data_t            op1_q     [1:NUM_PORTS];
  data_t            op2_q     [1:NUM_PORTS];
  logic [TAG_W-1:0] rr_ptr;

  logic             grant_any;
  logic [TAG_W-1:0] grant_idx;
  cmd_t             sel_cmd;
  data_t            sel_op1;
  data_t            sel_op2;

  logic             retire_vld;
  logic [TAG_W-1:0] retire_tag;
  logic             pipe_vld;
  resp_t            pipe_resp;
  data_t            pipe_data;
  logic [TAG_W-1:0] pipe_tag;

  // rr_ptr holds the first port to examine this cycle
  always_comb begin
    int q;
    q         = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      q = ((int'(rr_ptr) - 1 + k) % NUM_PORTS) + 1;
      if (!grant_any && state[q] == ST_PENDING) begin
        grant_any = 1'b1;
        grant_idx = TAG_W'(q);
      end
    end
  end

  always_comb begin
    sel_cmd = CMD_NOP;
    sel_op1 = '0;
    sel_op2 = '0;
    for (int p = 1; p <= NUM_PORTS; p++) begin
      if (grant_idx == TAG_W'(p)) begin
        sel_cmd = cmd_q[p];
        sel_op1 = op1_q[p];
        sel_op2 = op2_q[p];
      end
    end
  end

  always_comb begin
    logic won, done, seen;
    won  = 1'b0;
    done = 1'b0;
    seen = 1'b0;
    for (int p = 1; p <= NUM_PORTS; p++) begin
      state_nxt[p] = state[p];
      drop_set[p]  = 1'b0;
      won  = grant_any && (grant_idx == TAG_W'(p));
      done = retire_vld && (retire_tag == TAG_W'(p));
      seen = req_cmd_in[p] != CMD_NOP;
      case (state[p])
        ST_IDLE:     if (seen) state_nxt[p] = ST_WAIT_OP2;
        ST_WAIT_OP2: state_nxt[p] = ST_PENDING;
        ST_PENDING: begin
          // with a single stage, grant and response load share one edge
          if (won) state_nxt[p] = done ? ST_IDLE : ST_INFLIGHT;
          drop_set[p] = seen;
        end
        default: begin
          if (done) state_nxt[p] = ST_IDLE;
          drop_set[p] = seen;
        end
      endcase
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      for (int p = 1; p <= NUM_PORTS; p++) begin
        state[p]  <= ST_IDLE;
        drop_q[p] <= 1'b0;
      end
      rr_ptr <= TAG_W'(1);
    end else begin
      for (int p = 1; p <= NUM_PORTS; p++) begin
        state[p] <= state_nxt[p];
        if (drop_set[p]) drop_q[p] <= 1'b1;
      end
      if (grant_any) begin
        rr_ptr <= (grant_idx == TAG_W'(NUM_PORTS)) ? TAG_W'(1) : grant_idx + TAG_W'(1);
      end
    end
  end

  always_ff @(posedge c_clk) begin
    for (int p = 1; p <= NUM_PORTS; p++) begin
      if (state[p] == ST_IDLE && req_cmd_in[p] != CMD_NOP) begin
        cmd_q[p] <= req_cmd_in[p];
        op1_q[p] <= req_data_in[p];
      end
      if (state[p] == ST_WAIT_OP2) op2_q[p] <= req_data_in[p];
    end
  end

  calc_alu_pipe #(
    .LATENCY(LATENCY),
    .TAG_W  (TAG_W)
  ) u_alu (
    .clk       (c_clk),
    .rst       (reset),
    .in_vld    (grant_any),
    .in_cmd    (sel_cmd),
    .in_op1    (sel_op1),
    .in_op2    (sel_op2),
    .in_tag    (grant_idx),
    .retire_vld(retire_vld),
    .retire_tag(retire_tag),
    .out_vld   (pipe_vld),
    .out_resp  (pipe_resp),
    .out_data  (pipe_data),
    .out_tag   (pipe_tag)
  );

  always_comb begin
    for (int p = 1; p <= NUM_PORTS; p++) begin
      out_resp[p]  = RESP_NONE;
      out_data[p]  = '0;
      if (pipe_vld && pipe_tag == TAG_W'(p)) begin
        out_resp[p] = pipe_resp;
        out_data[p] = pipe_data;
      end
      port_busy[p] = state[p] != ST_IDLE;
      drop_err[p]  = drop_q[p];
    end
  end

endmodule

// File: tb/tb_calc_port_responder.sv
// Directed bench for calc_port_responder: a timestamp-based transaction model
// checked every cycle, plus literal expectations at the key response cycles.
module tb_calc_port_responder;
  import calc_pkg::*;

  localparam int NP  = 4;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:3]  cmd  [1:NP];
  logic [0:31] din  [1:NP];
  logic [0:1]  resp [1:NP];
  logic [0:31] dout [1:NP];
  logic        busy [1:NP];
  logic        derr [1:NP];

  calc_port_responder #(.NUM_PORTS(NP), .LATENCY(LAT)) dut (
    .c_clk      (clk),
    .reset      (rst),
    .req_cmd_in (cmd),
    .req_data_in(din),
    .out_resp   (resp),
    .out_data   (dout),
    .port_busy  (busy),
    .drop_err   (derr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, int p, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s port%0d got=%0h want=%0h @%0t", name, p, act, exp, $time);
    end
  endtask

  function automatic logic [33:0] model_result(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    longint s;
    case (c)
      4'd1: begin
        s = longint'(a) + longint'(b);
        if (s > 64'hFFFF_FFFF) return {2'd2, 32'd0};
        return {2'd1, a + b};
      end
      4'd2: begin
        if (b > a) return {2'd2, 32'd0};
        return {2'd1, a - b};
      end
      4'd5: return {2'd1, a << b[4:0]};
      4'd6: return {2'd1, a >> b[4:0]};
      default: return {2'd2, 32'd0};
    endcase
  endfunction

  // model: per port, accept cycle, grant status, due cycle and expected answer
  bit          m_out  [1:NP];
  bit          m_gr   [1:NP];
  int          m_a    [1:NP];
  int          m_rc   [1:NP];
  logic [3:0]  m_cmd  [1:NP];
  logic [31:0] m_op1  [1:NP];
  logic [1:0]  m_r    [1:NP];
  logic [31:0] m_d    [1:NP];
  bit          m_drop [1:NP];
  int          m_ptr = 1;
  int          t = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_ptr = 1;
      for (int p = 1; p <= NP; p++) begin
        m_out[p] = 0; m_gr[p] = 0; m_drop[p] = 0;
        chk("rst_resp", p, resp[p], 0);
        chk("rst_data", p, dout[p], 0);
        chk("rst_busy", p, busy[p], 0);
        chk("rst_drop", p, derr[p], 0);
      end
    end else begin
      bit g;
      int q;
      for (int p = 1; p <= NP; p++) begin
        bit vis;
        vis = m_out[p] && m_gr[p] && (m_rc[p] == t);
        if (vis) m_out[p] = 0;
        chk("resp", p, resp[p], vis ? m_r[p] : 2'd0);
        chk("data", p, dout[p], vis ? m_d[p] : 32'd0);
        chk("busy", p, busy[p], m_out[p]);
        chk("drop", p, derr[p], m_drop[p]);
      end
      g = 0;
      for (int k = 0; k < NP; k++) begin
        q = ((m_ptr - 1 + k) % NP) + 1;
        if (!g && m_out[q] && !m_gr[q] && t >= m_a[q] + 2) begin
          g = 1; m_gr[q] = 1; m_rc[q] = t + LAT; m_ptr = (q % NP) + 1;
        end
      end
      for (int p = 1; p <= NP; p++) begin
        if (m_out[p] && t == m_a[p] + 1) {m_r[p], m_d[p]} = model_result(m_cmd[p], m_op1[p], din[p]);
      end
      for (int p = 1; p <= NP; p++) begin
        if (cmd[p] != 4'd0) begin
          if (!m_out[p]) begin
            m_out[p] = 1; m_gr[p] = 0; m_a[p] = t; m_cmd[p] = cmd[p]; m_op1[p] = din[p];
          end else if (t != m_a[p] + 1) begin
            m_drop[p] = 1;
          end
        end
      end
    end
    t++;
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int p = 1; p <= NP; p++) begin
        cmd[p] = 4'd0;
        din[p] = 32'd0;
      end
    end
  endtask

  task automatic lit(string name, int p, logic [1:0] r, logic [31:0] d);
    chk({name, "_resp"}, p, resp[p], r);
    chk({name, "_data"}, p, dout[p], d);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog port0 got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 1; p <= NP; p++) begin
      cmd[p] = 4'd0;
      din[p] = 32'd0;
    end
    step(2);
    chk("lit_rst_busy", 1, busy[1], 0);
    lit("lit_rst", 1, 2'd0, 32'd0);
    rst = 1'b0;
    step(2);

    // ADD without carry on port 1
    cmd[1] = CMD_ADD; din[1] = 32'hFFFF_0000; step;
    din[1] = 32'h0000_FFFF; step;
    chk("lit_busy_pend", 1, busy[1], 1); step;
    lit("lit_add", 1, 2'd1, 32'hFFFF_FFFF);
    lit("lit_quiet", 2, 2'd0, 32'd0);
    step(2);

    // ADD overflow on port 2, SUB underflow on port 3, same cycle
    cmd[2] = CMD_ADD; din[2] = 32'h8000_0000;
    cmd[3] = CMD_SUB; din[3] = 32'd1; step;
    din[2] = 32'h8000_0000; din[3] = 32'd2; step;
    step;
    lit("lit_add_ovf", 2, 2'd2, 32'd0); step;
    lit("lit_sub_unf", 3, 2'd2, 32'd0);
    step(2);

    // shifts and invalid command on port 4, each issued in the prior response cycle
    cmd[4] = CMD_LSH; din[4] = 32'd1; step;
    din[4] = 32'h0000_0024; step;
    step;
    lit("lit_lsh", 4, 2'd1, 32'h0000_0010);
    cmd[4] = CMD_RSH; din[4] = 32'h8000_0000; step;
    din[4] = 32'd31; step;
    step;
    lit("lit_rsh", 4, 2'd1, 32'h0000_0001);
    cmd[4] = 4'd3; din[4] = 32'd5; step;
    din[4] = 32'd7; step;
    step;
    lit("lit_bad_cmd", 4, 2'd2, 32'd0);
    step(2);

    // all ports at once: serviced 1,2,3,4
    for (int p = 1; p <= NP; p++) begin cmd[p] = CMD_ADD; din[p] = p; end
    step;
    for (int p = 1; p <= NP; p++) din[p] = p;
    step;
    step;
    lit("lit_burst", 1, 2'd1, 32'd2); step;
    lit("lit_burst", 2, 2'd1, 32'd4); step;
    lit("lit_burst", 3, 2'd1, 32'd6); step;
    lit("lit_burst", 4, 2'd1, 32'd8);
    step(2);

    // single grant to port 2 rotates the pointer; next burst starts at port 3
    cmd[2] = CMD_ADD; din[2] = 32'd5; step;
    din[2] = 32'd6; step;
    step;
    lit("lit_single", 2, 2'd1, 32'd11);
    step(2);
    for (int p = 1; p <= NP; p++) begin cmd[p] = CMD_ADD; din[p] = p; end
    step;
    for (int p = 1; p <= NP; p++) din[p] = 32'd100;
    step;
    step;
    lit("lit_rot", 3, 2'd1, 32'd103); step;
    lit("lit_rot", 4, 2'd1, 32'd104); step;
    lit("lit_rot", 1, 2'd1, 32'd101); step;
    lit("lit_rot", 2, 2'd1, 32'd102);
    step(2);

    // command while busy is dropped; command in the response cycle is accepted
    cmd[1] = CMD_ADD; din[1] = 32'd10; step;
    din[1] = 32'd20; step;
    cmd[1] = CMD_SUB; din[1] = 32'd3; step;
    lit("lit_drop_rsp", 1, 2'd1, 32'd30);
    chk("lit_drop_set", 1, derr[1], 1);
    chk("lit_drop_other", 2, derr[2], 0);
    cmd[1] = CMD_ADD; din[1] = 32'd7; step;
    lit("lit_one_rsp", 1, 2'd0, 32'd0);
    din[1] = 32'd8; step;
    step;
    lit("lit_resp_cyc_cmd", 1, 2'd1, 32'd15);
    step(2);

    // reset while a SUB is pending discards it
    cmd[3] = CMD_SUB; din[3] = 32'd9; step;
    din[3] = 32'd4; step;
    rst = 1'b1;
    #1;
    chk("lit_rst_busy3", 3, busy[3], 0);
    chk("lit_rst_drop1", 1, derr[1], 0);
    lit("lit_rst_mid", 3, 2'd0, 32'd0);
    step;
    rst = 1'b0;
    step(4);
    cmd[3] = CMD_SUB; din[3] = 32'd9; step;
    din[3] = 32'd4; step;
    step;
    lit("lit_after_rst", 3, 2'd1, 32'd5);
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
